// File: rtl/cache_set_assoc.sv
// cache_set_assoc: write-back, write-allocate, WAYS-way set-associative data
// cache with true-LRU replacement and a word-wide backing-memory port.
// Optional flush engine enabled by defining CACHE_FLUSH_EN.
module cache_set_assoc #(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned SETS  = 8,
    parameter int unsigned WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic        re,
    input  logic        we,
`ifdef CACHE_FLUSH_EN
    input  logic        flush,
`endif
    output logic        done,
    output logic [31:0] dout,
    output logic [31:0] hit_cnt,
    output logic [31:0] tot_cnt,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_we,
    input  logic [31:0] mem_dout
);
    localparam int unsigned OB = $clog2(WORDS);
    localparam int unsigned IB = $clog2(SETS);
    localparam int unsigned AB = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned TB = 32 - OB - IB - 2;
    localparam logic [OB:0]   CNT_WB_LAST   = (OB+1)'(WORDS - 1);
    localparam logic [OB:0]   CNT_FILL_LAST = (OB+1)'(WORDS);
    localparam logic [AB-1:0] AGE_OLDEST    = AB'(WAYS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_FILL,
        S_INSTALL
`ifdef CACHE_FLUSH_EN
        , S_FLUSH
`endif
    } state_t;

    state_t r_state, w_next;

    logic          r_valid [WAYS][SETS];
    logic          r_dirty [WAYS][SETS];
    logic [TB-1:0] r_tag   [WAYS][SETS];
    logic [AB-1:0] r_age   [WAYS][SETS];
    logic [31:0]   r_data  [WAYS][SETS][WORDS];
    logic [31:0]   r_buf   [WORDS];

    logic [AB-1:0] r_victim;
    logic [OB:0]   r_cnt;
    logic [31:0]   r_tot;
    logic [31:0]   r_miss;

    logic [OB-1:0] w_off;
    logic [IB-1:0] w_idx;
    logic [TB-1:0] w_tag;
    logic          w_req;
    logic          w_hit;
    logic [AB-1:0] w_hway;
    logic [AB-1:0] w_vic;
    logic          w_vfound;
    logic          w_tot_inc;
    logic          w_miss_inc;
    logic [OB-1:0] w_bidx;
    logic          w_unused_addr;

`ifdef CACHE_FLUSH_EN
    localparam logic [IB-1:0] SET_LAST = IB'(SETS - 1);
    logic [IB-1:0] r_fset;
    logic [AB-1:0] r_fway;
    logic          r_fwr;
    logic          w_flast;
    assign w_flast = (r_fset == SET_LAST) && (r_fway == AGE_OLDEST);
`endif

    assign w_off         = addr[OB+1:2];
    assign w_idx         = addr[OB+IB+1:OB+2];
    assign w_tag         = addr[31:OB+IB+2];
    assign w_req         = re | we;
    assign w_bidx        = r_cnt[OB-1:0] - OB'(1);
    assign w_unused_addr = ^addr[1:0];

    assign dout    = r_data[w_hway][w_idx][w_off];
    assign tot_cnt = r_tot;
    assign hit_cnt = r_tot - r_miss;

    // Hit detection and victim choice: first invalid way, else the LRU way
    always_comb begin
        w_hit    = 1'b0;
        w_hway   = '0;
        w_vic    = '0;
        w_vfound = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit  = 1'b1;
                w_hway = AB'(w);
            end
            if (!w_vfound && !r_valid[w][w_idx]) begin
                w_vic    = AB'(w);
                w_vfound = 1'b1;
            end
        end
        if (!w_vfound) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (r_age[w][w_idx] == AGE_OLDEST) w_vic = AB'(w);
            end
        end
    end

    // Next-state and memory-port outputs
    always_comb begin
        w_next     = r_state;
        done       = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;
        w_tot_inc  = 1'b0;
        w_miss_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                done      = !w_req || w_hit;
                w_tot_inc = w_req && w_hit;
                if (w_req && !w_hit) begin
                    w_miss_inc = 1'b1;
                    w_next = (r_valid[w_vic][w_idx] && r_dirty[w_vic][w_idx]) ? S_WB : S_FILL;
                end
`ifdef CACHE_FLUSH_EN
                else if (!w_req && flush) begin
                    w_next = S_FLUSH;
                end
`endif
            end
            S_WB: begin
                mem_we   = 1'b1;
                mem_addr = {r_tag[r_victim][w_idx], w_idx, r_cnt[OB-1:0], 2'b00};
                mem_din  = r_data[r_victim][w_idx][r_cnt[OB-1:0]];
                if (r_cnt == CNT_WB_LAST) w_next = S_FILL;
            end
            S_FILL: begin
                if (!r_cnt[OB]) mem_addr = {w_tag, w_idx, r_cnt[OB-1:0], 2'b00};
                if (r_cnt == CNT_FILL_LAST) w_next = S_INSTALL;
            end
            S_INSTALL: begin
                w_next = S_IDLE;
            end
`ifdef CACHE_FLUSH_EN
            S_FLUSH: begin
                if (r_fwr) begin
                    mem_we   = 1'b1;
                    mem_addr = {r_tag[r_fway][r_fset], r_fset, r_cnt[OB-1:0], 2'b00};
                    mem_din  = r_data[r_fway][r_fset][r_cnt[OB-1:0]];
                    if (w_flast && (r_cnt == CNT_WB_LAST)) w_next = S_IDLE;
                end else if (w_flast && !(r_valid[r_fway][r_fset] && r_dirty[r_fway][r_fset])) begin
                    w_next = S_IDLE;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Controller state, word counter, victim latch and access counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_victim <= '0;
            r_tot    <= '0;
            r_miss   <= '0;
`ifdef CACHE_FLUSH_EN
            r_fset   <= '0;
            r_fway   <= '0;
            r_fwr    <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_tot_inc)  r_tot  <= r_tot + 32'd1;
            if (w_miss_inc) r_miss <= r_miss + 32'd1;
            case (r_state)
                S_IDLE: begin
                    r_cnt    <= '0;
                    r_victim <= w_vic;
`ifdef CACHE_FLUSH_EN
                    r_fset   <= '0;
                    r_fway   <= '0;
                    r_fwr    <= 1'b0;
`endif
                end
                S_WB:   r_cnt <= (r_cnt == CNT_WB_LAST) ? '0 : r_cnt + (OB+1)'(1);
                S_FILL: r_cnt <= r_cnt + (OB+1)'(1);
`ifdef CACHE_FLUSH_EN
                // A line is advanced after its check cycle if clean, or after its last write word
                S_FLUSH: begin
                    if (r_fwr && (r_cnt != CNT_WB_LAST)) begin
                        r_cnt <= r_cnt + (OB+1)'(1);
                    end else if (!r_fwr && r_valid[r_fway][r_fset] && r_dirty[r_fway][r_fset]) begin
                        r_fwr <= 1'b1;
                        r_cnt <= '0;
                    end else begin
                        r_fwr <= 1'b0;
                        r_cnt <= '0;
                        if (r_fway == AGE_OLDEST) begin
                            r_fway <= '0;
                            r_fset <= r_fset + IB'(1);
                        end else begin
                            r_fway <= r_fway + AB'(1);
                        end
                    end
                end
`endif
                default: r_cnt <= '0;
            endcase
        end
    end

    // Line status: valid/dirty flags and LRU ages
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    r_valid[w][s] <= 1'b0;
                    r_dirty[w][s] <= 1'b0;
                    r_age[w][s]   <= AB'(w);
                end
            end
        end else begin
            if (r_state == S_IDLE && w_req && w_hit) begin
                if (we) r_dirty[w_hway][w_idx] <= 1'b1;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (r_age[w][w_idx] < r_age[w_hway][w_idx])
                        r_age[w][w_idx] <= r_age[w][w_idx] + AB'(1);
                end
                r_age[w_hway][w_idx] <= '0;
            end
            if (r_state == S_INSTALL) begin
                r_valid[r_victim][w_idx] <= 1'b1;
                r_dirty[r_victim][w_idx] <= 1'b0;
            end
`ifdef CACHE_FLUSH_EN
            if (r_state == S_FLUSH && r_fwr && (r_cnt == CNT_WB_LAST))
                r_dirty[r_fway][r_fset] <= 1'b0;
`endif
        end
    end

    // Data, tag and fill buffer storage (contents need no reset)
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_FILL && r_cnt != '0) r_buf[w_bidx] <= mem_dout;
            if (r_state == S_IDLE && we && w_hit) r_data[w_hway][w_idx][w_off] <= din;
            if (r_state == S_INSTALL) begin
                r_tag[r_victim][w_idx] <= w_tag;
                for (int unsigned k = 0; k < WORDS; k++)
                    r_data[r_victim][w_idx][k] <= r_buf[k];
            end
        end
    end
endmodule

// File: tb/tb_cache_set_assoc.sv
// Self-checking bench for cache_set_assoc with a behavioural 1-cycle memory.
// Define CACHE_FLUSH_EN to also exercise the flush engine.
module tb_cache_set_assoc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] din = '0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic        done;
    logic [31:0] dout, hit_cnt, tot_cnt, mem_addr, mem_din, mem_dout;
    logic        mem_we;
`ifdef CACHE_FLUSH_EN
    logic        flush = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    cache_set_assoc #(.WAYS(2), .SETS(8), .WORDS(8)) dut (
        .clk(clk), .rst(rst), .addr(addr), .din(din), .re(re), .we(we),
`ifdef CACHE_FLUSH_EN
        .flush(flush),
`endif
        .done(done), .dout(dout), .hit_cnt(hit_cnt), .tot_cnt(tot_cnt),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Backing memory: unwritten word i reads 0x1000+i; log of every write
    logic [31:0] mem [int unsigned];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int unsigned i;
        i = int'(a[31:2]);
        return mem.exists(i) ? mem[i] : 32'h1000 + i;
    endfunction

    always @(posedge clk) begin
        mem_dout <= mem_rd(mem_addr);
        if (mem_we) begin
            mem[int'(mem_addr[31:2])] = mem_din;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_din);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       tag;
        logic [31:0] dout;
        int          lat;
        bit          chk;
    } exp_t;
    exp_t sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request, wait for done (bounded), compare against the scoreboard entry
    task automatic access(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic r, input logic w, input int lat,
                          input logic [31:0] exp_dout, input bit chk);
        exp_t e, g;
        int n;
        e.tag = tag; e.dout = exp_dout; e.lat = lat; e.chk = chk;
        sb.push_back(e);
        @(posedge clk); #1;
        addr = a; din = d; re = r; we = w;
        n = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            n++;
            if (n > 200) break;
        end
        g = sb.pop_front();
        check({g.tag, "_lat"}, 32'(n), 32'(g.lat));
        if (g.chk) check({g.tag, "_dout"}, dout, g.dout);
        @(posedge clk); #1;
        re = 1'b0; we = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; re = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

`ifdef CACHE_FLUSH_EN
    task automatic run_flush(input string tag, input int exp_cyc, input int exp_wr);
        int n, s;
        s = wr_addr_q.size();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            n++;
            if (n > 500) break;
        end
        check({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
        check({tag, "_writes"}, 32'(wr_addr_q.size() - s), 32'(exp_wr));
    endtask
`endif

    initial begin
        int s;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_done", 32'(done), 32'd1);
        check("rst_hit", hit_cnt, 32'd0);
        check("rst_tot", tot_cnt, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);

        // Cold read miss then hit in same block
        access("cold_rd", 32'h44, '0, 1'b1, 1'b0, 11, 32'h1011, 1'b1);
        access("hit_rd", 32'h48, '0, 1'b1, 1'b0, 0, 32'h1012, 1'b1);
        @(negedge clk);
        check("cold_hit_cnt", hit_cnt, 32'd1);
        check("cold_tot_cnt", tot_cnt, 32'd2);

        // LRU replacement within set 0
        do_reset();
        s = wr_addr_q.size();
        access("lru_a", 32'h000, '0, 1'b1, 1'b0, 11, 32'h1000, 1'b1);
        access("lru_b", 32'h100, '0, 1'b1, 1'b0, 11, 32'h1040, 1'b1);
        access("lru_a2", 32'h000, '0, 1'b1, 1'b0, 0, 32'h1000, 1'b1);
        access("lru_c", 32'h200, '0, 1'b1, 1'b0, 11, 32'h1080, 1'b1);
        check("lru_no_wb", 32'(wr_addr_q.size() - s), 32'd0);
        access("lru_a3", 32'h000, '0, 1'b1, 1'b0, 0, 32'h1000, 1'b1);
        access("lru_b2", 32'h100, '0, 1'b1, 1'b0, 11, 32'h1040, 1'b1);
        @(negedge clk);
        check("lru_hit_cnt", hit_cnt, 32'd2);
        check("lru_tot_cnt", tot_cnt, 32'd6);

        // Dirty eviction with write-back of block 0
        do_reset();
        access("wr_miss", 32'h004, 32'hDEADBEEF, 1'b0, 1'b1, 11, '0, 1'b0);
        access("dirty_b", 32'h100, '0, 1'b1, 1'b0, 11, 32'h1040, 1'b1);
        s = wr_addr_q.size();
        access("dirty_evict", 32'h200, '0, 1'b1, 1'b0, 19, 32'h1080, 1'b1);
        check("wb_count", 32'(wr_addr_q.size() - s), 32'd8);
        if (wr_addr_q.size() >= s + 8) begin
            for (int k = 0; k < 8; k++) check("wb_addr", wr_addr_q[s + k], 32'(4 * k));
            check("wb_data1", wr_data_q[s + 1], 32'hDEADBEEF);
        end
        check("mem_word1", mem_rd(32'h004), 32'hDEADBEEF);

        // Simultaneous re/we: pre-write data visible, then new data
        access("rw_fill", 32'h008, '0, 1'b1, 1'b0, 11, 32'h1002, 1'b1);
        access("rw_both", 32'h008, 32'hA5A5A5A5, 1'b1, 1'b1, 0, 32'h1002, 1'b1);
        access("rw_after", 32'h008, '0, 1'b1, 1'b0, 0, 32'hA5A5A5A5, 1'b1);

        // Reset during FILL word 3 abandons the miss
        @(posedge clk); #1;
        addr = 32'h300; re = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("fill3_addr", mem_addr, 32'h30C);
        #4 rst = 1'b1; re = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_done", 32'(done), 32'd1);
        check("midrst_hit", hit_cnt, 32'd0);
        check("midrst_tot", tot_cnt, 32'd0);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        access("midrst_reread", 32'h300, '0, 1'b1, 1'b0, 11, 32'h10C0, 1'b1);

`ifdef CACHE_FLUSH_EN
        // Flush two dirty lines, then flush an all-clean cache
        do_reset();
        access("fl_w0", 32'h000, 32'h11111111, 1'b0, 1'b1, 11, '0, 1'b0);
        access("fl_w1", 32'h120, 32'h22222222, 1'b0, 1'b1, 11, '0, 1'b0);
        run_flush("flush1", 32, 16);
        check("flush_mem0", mem_rd(32'h000), 32'h11111111);
        check("flush_mem120", mem_rd(32'h120), 32'h22222222);
        run_flush("flush2", 16, 0);
        @(negedge clk);
        check("flush_tot", tot_cnt, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_set_assoc.md
Name: cache_set_assoc

Overview:
- Parametrised write-back, write-allocate, N-way set-associative data cache with true-LRU replacement.
- Next generation of the team's direct-mapped data cache; same CPU-side handshake (re/we, done, hit/total counters).
- Sits between the CPU data port and a word-wide single-port backing memory with 1-cycle read latency.
- Backing memory is exposed as ports rather than instantiated inside, so the bench can model it.

Parameters:
- WAYS, 2: associativity; power of two, 1..8.
- SETS, 8: sets per way; power of two, >=2.
- WORDS, 8: 32-bit words per block; power of two, >=2.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous and active-high.
- addr  input  32  CPU byte address; word aligned.
- din  input  32  CPU write data.
- re  input  1  read request.
- we  input  1  write request.
- done  output  1  request complete / cache idle.
- dout  output  32  read data; valid when done & re.
- hit_cnt  output  32  accesses that hit.
- tot_cnt  output  32  completed accesses.
- mem_addr  output  32  backing-memory byte address.
- mem_din  output  32  backing-memory write data.
- mem_we  output  1  backing-memory write strobe.
- mem_dout  input  32  backing-memory read data, valid one cycle after mem_addr.

Behaviour:
- Address split:
  - offset = addr[OB+1:2], OB = log2(WORDS)
  - index = next log2(SETS) bits
  - tag = remaining upper bits
- Per line: valid, dirty, tag, WORDS words, log2(WAYS)-bit age.
- Reset (synchronous, rst=1):
  - all valid/dirty cleared; age[way] = way
  - FSM -> IDLE; hit_cnt = tot_cnt = 0
  - mem_we = 0, mem_addr = 0, mem_din = 0; done = 1 the next cycle
  - Reset mid-miss/flush abandons the operation with no further memory writes.
- States: IDLE, WB, FILL, INSTALL, FLUSH (optional).
- IDLE:
  - done = (re|we)==0 or hit. Hit is combinational (any valid way with matching tag).
  - Read hit: dout combinational from the hit way.
  - Write hit: word written at the edge; line marked dirty.
  - re & we together are treated as a write; dout shows the pre-write word.
  - Miss: choose the victim (lowest-index invalid way, else the way with age == WAYS-1). Go to WB if the victim is valid & dirty, else FILL.
- LRU update on every completed access to way w with age a: ways with age < a increment; w gets age 0.
- WB, WORDS cycles:
  - cycle k: mem_we = 1, mem_addr = {victim tag, index, k, 2'b00}, mem_din = victim word k. Then FILL.
- FILL, WORDS+1 cycles:
  - cycle k (k < WORDS): mem_addr = {addr block, k, 2'b00}; mem_we = 0.
  - mem_dout captured into the line buffer one cycle later.
- INSTALL, 1 cycle: buffer written to the victim way; valid = 1, dirty = 0, tag set. Return to IDLE, where the request now hits and completes (write merges at that edge).
- Latency from first request cycle to done (WORDS=8): hit 0; clean miss WORDS+3 = 11; dirty miss 2*WORDS+3 = 19.
- Requester holds addr/din/re/we stable until done. Changing them mid-miss is undefined, except that deasserting both returns to IDLE after the current miss.
- Counters:
  - tot_cnt increments when (re|we) & done.
  - Miss counter increments on each IDLE->WB/FILL transition; hit_cnt = tot_cnt - misses.
  - Counters wrap modulo 2^32.
- mem_we is 0 outside WB/FLUSH; mem_addr and mem_din are 0 in IDLE.

Optional Feature:
- CACHE_FLUSH_EN defined:
  - Extra input flush (1 bit), sampled only in IDLE with re=we=0.
  - A flush pulse enters FLUSH from the next cycle; done = 0 throughout.
  - Visits every set/way in order (set-major, then way): 1 check cycle per line, plus WORDS write cycles if dirty.
  - Written lines have dirty cleared; valid and age are kept.
  - Returns to IDLE after the last line. Counters unaffected.
  - flush together with re|we: request served, flush ignored.
- Undefined: no flush port, no FLUSH state.

Test Plan:
- Cold read miss, memory word i = 0x1000+i: rst, read 0x44 -> done at cycle 11, dout=0x1011; read 0x48 -> done same cycle, dout=0x1012, hit_cnt=1, tot_cnt=2.
- LRU: read 0x000, 0x100, 0x000, 0x200 -> 0x200 evicts 0x100 (no mem_we); read 0x000 hits; read 0x100 misses; final hit_cnt=2, tot_cnt=6.
- Dirty eviction: write 0xDEADBEEF to 0x004, read 0x100, read 0x200 -> 8 mem_we cycles, mem_addr 0x000..0x01C, word at 0x004=0xDEADBEEF, done at cycle 19.
- re=we=1 at 0x008 din=0xA5A5A5A5 on resident line -> dout=old value same cycle; next read 0x008 returns 0xA5A5A5A5.
- rst asserted in FILL cycle 3 -> next cycle done=1, hit_cnt=tot_cnt=0, mem_we=0; re-read same address misses again (11 cycles).
- CACHE_FLUSH_EN: dirty lines at 0x000 and 0x120, pulse flush -> done=0 for 16+16=32 cycles, 16 mem_we writes; second flush takes 16 cycles with no writes.
